// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (core, DMA) for a single unified memory port with fixed
// read latency. One transaction at a time; core preferred, DMA protected from starvation.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_dma
);

  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  lat_cnt;
  logic [STV_W-1:0]  starve_cnt;
  logic              lat_we;
  logic              lat_owner;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              req_any;
  logic              dma_wins;
  logic              rdata_last;

  assign req_any    = core_req | dma_req;
  // Core wins unless DMA is alone or has waited through STARVE_MAX core grants.
  assign dma_wins   = dma_req & (~core_req | (starve_cnt == STV_W'(STARVE_MAX)));
  assign rdata_last = (state == WAIT) && (lat_cnt == CNT_W'(1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = lat_we ? RESP : WAIT;
      WAIT:    if (rdata_last) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt <= '0;
    end else if (state == ISSUE) begin
      lat_cnt <= CNT_W'(MEM_LAT);
    end else if (state == WAIT) begin
      lat_cnt <= lat_cnt - CNT_W'(1);
    end
  end

  // Request latch and starvation bookkeeping happen only at an IDLE arbitration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_we     <= 1'b0;
      lat_owner  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      starve_cnt <= '0;
    end else if (state == IDLE && req_any) begin
      lat_owner <= dma_wins;
      lat_we    <= dma_wins ? dma_we    : core_we;
      lat_addr  <= dma_wins ? dma_addr  : core_addr;
      lat_wdata <= dma_wins ? dma_wdata : core_wdata;
      if (dma_wins || !dma_req)                      starve_cnt <= '0;
      else if (starve_cnt != STV_W'(STARVE_MAX))     starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_rdata <= '0;
      dma_rdata  <= '0;
    end else if (rdata_last) begin
      if (lat_owner) dma_rdata  <= mem_rdata;
      else           core_rdata <= mem_rdata;
    end
  end

  assign mem_en    = (state == ISSUE);
  assign mem_we    = lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign busy      = (state != IDLE);
  assign grant_dma = lat_owner;
  assign core_ack  = (state == RESP) && !lat_owner;
  assign dma_ack   = (state == RESP) &&  lat_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected acks are queued when requests are
// driven and popped when an ack appears; a latency-pipelined memory model answers reads.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32, DATA_W = 32, MEM_LAT = 2, STARVE_MAX = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic core_req = 0, core_we = 0, dma_req = 0, dma_we = 0;
  logic [ADDR_W-1:0] core_addr = '0, dma_addr = '0;
  logic [DATA_W-1:0] core_wdata = '0, dma_wdata = '0;
  logic [DATA_W-1:0] core_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic core_ack, dma_ack, mem_en, mem_we, busy, grant_dma;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT),
                     .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ack(core_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_dma(grant_dma)
  );

  typedef struct {
    bit          dma;
    logic [31:0] rdata;
    int          ack_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] exp_core_rd = '0;
  logic [31:0] exp_dma_rd = '0;

  // Unwritten locations read back a fixed address-derived pattern.
  function automatic logic [31:0] pat(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {~a[15:0], a[15:0] ^ 16'h5A5A};
  endfunction

  logic [DATA_W-1:0] mem_model [0:63];
  bit                mem_wv    [0:63];
  logic [DATA_W-1:0] rd_pipe   [0:MEM_LAT-1];

  assign mem_rdata = rd_pipe[MEM_LAT-1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_en && !mem_we)
      rd_pipe[0] <= mem_wv[mem_addr[7:2]] ? mem_model[mem_addr[7:2]] : pat(mem_addr);
    else
      rd_pipe[0] <= $urandom;
    if (mem_en && mem_we) begin
      mem_model[mem_addr[7:2]] <= mem_wdata;
      mem_wv[mem_addr[7:2]]    <= 1'b1;
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({mem_en, mem_we, busy, core_ack, dma_ack, grant_dma} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {mem_en, mem_we, busy, core_ack, dma_ack, grant_dma});
    end
    total++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      bad++; $display("FAIL reset_mem got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    total++;
    if (core_rdata !== '0 || dma_rdata !== '0) begin
      bad++; $display("FAIL reset_rdata got core=%h dma=%h want 0", core_rdata, dma_rdata);
    end
  endtask

  task automatic test_core_read();
    exp_t e;
    core_req = 1; core_we = 0; core_addr = 32'h10;
    sb_q.push_back('{dma: 1'b0, rdata: 32'hDEADBEEF, ack_cyc: cyc + 4});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      total++;
      if (mem_en !== (k == 1)) begin
        bad++; $display("FAIL core_read_en k=%0d got=%b want=%b", k, mem_en, (k == 1));
      end
      if (k == 1) begin
        total++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h10) begin
          bad++; $display("FAIL core_read_issue got we=%b addr=%h want we=0 addr=10", mem_we, mem_addr);
        end
      end
      total++;
      if (dma_ack !== 1'b0) begin
        bad++; $display("FAIL core_read_dma_ack k=%0d got=%b want=0", k, dma_ack);
      end
      if (core_ack === 1'b1) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++; $display("FAIL core_read_ack unexpected ack at cycle %0d", cyc);
        end else begin
          e = sb_q.pop_front();
          if (e.dma || e.ack_cyc != cyc || core_rdata !== e.rdata) begin
            bad++;
            $display("FAIL core_read_ack got cyc=%0d data=%h want cyc=%0d data=%h",
                     cyc, core_rdata, e.ack_cyc, e.rdata);
          end
        end
        exp_core_rd = 32'hDEADBEEF;
        core_req = 0;
      end
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL core_read_missing got pending=%0d want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_dma_write();
    exp_t e;
    dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h1234;
    sb_q.push_back('{dma: 1'b1, rdata: exp_dma_rd, ack_cyc: cyc + 2});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++;
      if (mem_en !== (k == 1)) begin
        bad++; $display("FAIL dma_write_en k=%0d got=%b want=%b", k, mem_en, (k == 1));
      end
      if (k == 1) begin
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h1234) begin
          bad++;
          $display("FAIL dma_write_issue got we=%b addr=%h wdata=%h want 1/20/1234",
                   mem_we, mem_addr, mem_wdata);
        end
      end
      if (core_ack === 1'b1 || dma_ack === 1'b1) begin
        total++;
        if (core_ack === 1'b1 || sb_q.size() == 0) begin
          bad++; $display("FAIL dma_write_ack unexpected ack core=%b cyc=%0d", core_ack, cyc);
        end else begin
          e = sb_q.pop_front();
          if (e.ack_cyc != cyc || dma_rdata !== e.rdata || grant_dma !== 1'b1 ||
              core_rdata !== exp_core_rd) begin
            bad++;
            $display("FAIL dma_write_ack got cyc=%0d drd=%h gnt=%b crd=%h want cyc=%0d drd=%h gnt=1 crd=%h",
                     cyc, dma_rdata, grant_dma, core_rdata, e.ack_cyc, e.rdata, exp_core_rd);
          end
        end
        dma_req = 0;
      end
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL dma_write_missing got pending=%0d want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_both_reads();
    exp_t e;
    logic exp_gnt;
    core_req = 1; core_we = 0; core_addr = 32'h10;
    dma_req  = 1; dma_we  = 0; dma_addr  = 32'h20;
    sb_q.push_back('{dma: 1'b0, rdata: 32'hDEADBEEF, ack_cyc: cyc + 4});
    sb_q.push_back('{dma: 1'b1, rdata: 32'h1234,     ack_cyc: cyc + 9});
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      exp_gnt = (k >= 6);
      total++;
      if (mem_en !== (k == 1 || k == 6) || grant_dma !== exp_gnt) begin
        bad++;
        $display("FAIL both_seq k=%0d got en=%b gnt=%b want en=%b gnt=%b",
                 k, mem_en, grant_dma, (k == 1 || k == 6), exp_gnt);
      end
      if (k == 6) begin
        total++;
        if (mem_addr !== 32'h20) begin
          bad++; $display("FAIL both_dma_addr got=%h want=20", mem_addr);
        end
      end
      if (core_ack === 1'b1 || dma_ack === 1'b1) begin
        total++;
        if (sb_q.size() == 0 || (core_ack === 1'b1 && dma_ack === 1'b1)) begin
          bad++; $display("FAIL both_ack unexpected core=%b dma=%b cyc=%0d", core_ack, dma_ack, cyc);
        end else begin
          e = sb_q.pop_front();
          if (e.dma != dma_ack || e.ack_cyc != cyc ||
              (dma_ack ? dma_rdata : core_rdata) !== e.rdata) begin
            bad++;
            $display("FAIL both_ack got dma=%b cyc=%0d data=%h want dma=%b cyc=%0d data=%h",
                     dma_ack, cyc, dma_ack ? dma_rdata : core_rdata, e.dma, e.ack_cyc, e.rdata);
          end
        end
        if (dma_ack === 1'b1) dma_req = 0;
        else                  core_req = 0;
      end
    end
    exp_dma_rd = 32'h1234;
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL both_missing got pending=%0d want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_starvation();
    exp_t e;
    int   acks = 0;
    bit   order [0:8] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    core_req = 1; core_we = 1; core_addr = 32'h30; core_wdata = 32'hC0C0;
    dma_req  = 1; dma_we  = 1; dma_addr  = 32'h34; dma_wdata  = 32'hD0D0;
    for (int i = 0; i < 9; i++)
      sb_q.push_back('{dma: order[i], rdata: order[i] ? exp_dma_rd : exp_core_rd,
                       ack_cyc: cyc + 2 + 3 * i});
    for (int k = 1; k <= 40 && acks < 9; k++) begin
      @(negedge clk);
      if (core_ack === 1'b1 || dma_ack === 1'b1) begin
        acks++;
        total++;
        if (sb_q.size() == 0 || (core_ack === 1'b1 && dma_ack === 1'b1)) begin
          bad++; $display("FAIL starve_ack unexpected core=%b dma=%b cyc=%0d", core_ack, dma_ack, cyc);
        end else begin
          e = sb_q.pop_front();
          if (e.dma != dma_ack || e.ack_cyc != cyc ||
              (dma_ack ? dma_rdata : core_rdata) !== e.rdata) begin
            bad++;
            $display("FAIL starve_ack #%0d got dma=%b cyc=%0d want dma=%b cyc=%0d",
                     acks, dma_ack, cyc, e.dma, e.ack_cyc);
          end
        end
        if (acks == 9) begin core_req = 0; dma_req = 0; end
      end
    end
    core_req = 0; dma_req = 0;
    repeat (2) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL starve_missing got pending=%0d want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    core_req = 1; core_we = 0; core_addr = 32'h10;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b1 || mem_en !== 1'b0) begin
      bad++; $display("FAIL rstmid_wait got busy=%b en=%b want busy=1 en=0", busy, mem_en);
    end
    reset = 1'b0; core_req = 0;
    #1;
    total++;
    if ({mem_en, mem_we, busy, core_ack, dma_ack, grant_dma} !== 6'b0 ||
        mem_addr !== '0 || mem_wdata !== '0 || core_rdata !== '0 || dma_rdata !== '0) begin
      bad++;
      $display("FAIL rstmid_async got ctrl=%b addr=%h crd=%h drd=%h want all 0",
               {mem_en, mem_we, busy, core_ack, dma_ack, grant_dma}, mem_addr, core_rdata, dma_rdata);
    end
    exp_core_rd = '0; exp_dma_rd = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (core_ack !== 1'b0 || dma_ack !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL rstmid_quiet k=%0d got ack=%b%b busy=%b want 000", k, core_ack, dma_ack, busy);
      end
    end
    core_req = 1; core_we = 0; core_addr = 32'h8;
    sb_q.push_back('{dma: 1'b0, rdata: pat(32'h8), ack_cyc: cyc + 4});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (core_ack === 1'b1) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++; $display("FAIL rstmid_ack unexpected at cycle %0d", cyc);
        end else begin
          e = sb_q.pop_front();
          if (e.ack_cyc != cyc || core_rdata !== e.rdata) begin
            bad++;
            $display("FAIL rstmid_ack got cyc=%0d data=%h want cyc=%0d data=%h",
                     cyc, core_rdata, e.ack_cyc, e.rdata);
          end
        end
        exp_core_rd = pat(32'h8);
        core_req = 0;
      end
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL rstmid_missing got pending=%0d want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          en_cyc[$];
    logic [31:0] en_addr[$];
    int          acks = 0;
    core_req = 1; core_we = 0; core_addr = 32'h0;
    sb_q.push_back('{dma: 1'b0, rdata: pat(32'h0), ack_cyc: cyc + 4});
    sb_q.push_back('{dma: 1'b0, rdata: pat(32'h4), ack_cyc: cyc + 9});
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (mem_en === 1'b1) begin
        en_cyc.push_back(cyc);
        en_addr.push_back(mem_addr);
      end
      if (core_ack === 1'b1) begin
        acks++;
        total++;
        if (sb_q.size() == 0) begin
          bad++; $display("FAIL b2b_ack unexpected at cycle %0d", cyc);
        end else begin
          e = sb_q.pop_front();
          if (e.ack_cyc != cyc || core_rdata !== e.rdata) begin
            bad++;
            $display("FAIL b2b_ack #%0d got cyc=%0d data=%h want cyc=%0d data=%h",
                     acks, cyc, core_rdata, e.ack_cyc, e.rdata);
          end
        end
        if (acks == 1) core_addr = 32'h4;
        else           core_req = 0;
      end
    end
    total++;
    if (en_cyc.size() != 2) begin
      bad++; $display("FAIL b2b_en_count got=%0d want=2", en_cyc.size());
    end else if (en_cyc[1] - en_cyc[0] != 5 || en_addr[0] !== 32'h0 || en_addr[1] !== 32'h4) begin
      bad++;
      $display("FAIL b2b_en_spacing got gap=%0d addrs=%h,%h want gap=5 addrs=0,4",
               en_cyc[1] - en_cyc[0], en_addr[0], en_addr[1]);
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL b2b_missing got pending=%0d want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_dma_write();
    test_both_reads();
    test_starvation();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single unified instruction/data memory port between two requesters: the multicycle RV32 core and the DMA/program loader. Each requester uses a level req / one-cycle ack handshake. The arbiter sequences one memory transaction at a time and handles fixed read latency. The core stalls its controller FSM until core_ack.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from mem_en to valid mem_rdata (legal range >=1; 0 is a simulation error)
STARVE_MAX, 4, max consecutive core grants while dma_req is pending

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
core_req  in  1  core transaction request (level)
core_we  in  1  1=write, 0=read
core_addr  in  ADDR_W  core address
core_wdata  in  DATA_W  core write data
core_rdata  out  DATA_W  core read data, valid with core_ack
core_ack  out  1  one-cycle completion pulse to core
dma_req  in  1  DMA transaction request (level)
dma_we  in  1  1=write, 0=read
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_rdata  out  DATA_W  DMA read data, valid with dma_ack
dma_ack  out  1  one-cycle completion pulse to DMA
mem_en  out  1  memory strobe, exactly one cycle per transaction
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  1 when state != IDLE
grant_dma  out  1  current/last owner: 1=DMA, 0=core

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE. All outputs, the latched request, the owner and the starvation counter go to 0. Any in-flight transaction is dropped and no ack is issued for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high in cycle c, choose a winner and latch we/addr/wdata/owner at the end of cycle c. Move to ISSUE. Otherwise stay in IDLE.
- ISSUE (cycle c+1): mem_en=1; mem_we/mem_addr/mem_wdata come from the latched values.
  - Write: go to RESP.
  - Read: go to WAIT with the counter loaded to MEM_LAT.
- WAIT: decrement the counter each cycle. When mem_rdata is valid (cycle c+1+MEM_LAT), register it into the winner's rdata and go to RESP.
- RESP: assert the winner's ack for one cycle, then return to IDLE.
- Latency from req to ack: write = 2 cycles (ack in c+2); read = MEM_LAT+2 cycles (ack in c+2+MEM_LAT).
- Handshake:
  - Requesters hold req and payload stable until ack.
  - A registered requester that drops req at the edge ending the ack cycle is not re-served.
  - req still high in the IDLE cycle after RESP starts a new transaction.
  - The minimum gap between transactions is 1 IDLE cycle.
- mem_addr/mem_wdata/mem_we hold their latched values outside ISSUE; only mem_en is qualified.
- rdata registers change only on a read ack to that requester. Writes leave both rdata registers unchanged.
- Arbitration:
  - Core wins by default.
  - starve_cnt increments on each core grant made while dma_req=1.
  - When starve_cnt==STARVE_MAX and both requesters are high, DMA wins.
  - starve_cnt clears on any DMA grant, or on an arbitration where dma_req=0. It saturates at STARVE_MAX.
- A req change during ISSUE/WAIT/RESP is ignored; it is sampled only in IDLE.
- grant_dma updates at latch time and holds through IDLE.

Test Plan:
1. MEM_LAT=2. Core read, core_req=1 in cycle 0, core_addr=0x10; memory returns 0xDEADBEEF in cycle 3 -> mem_en=1/mem_we=0/mem_addr=0x10 in cycle 1 only; core_ack=1 in cycle 4 with core_rdata=0xDEADBEEF; dma_ack stays 0.
2. DMA write, dma_addr=0x20, dma_wdata=0x1234, req in cycle 0 -> mem_en=mem_we=1 with those values in cycle 1; dma_ack in cycle 2; dma_rdata unchanged; grant_dma=1.
3. Both reads requested in cycle 0 -> core served first (ack cycle 4). DMA latched in cycle 5 (IDLE), mem_en in cycle 6, dma_ack in cycle 9. grant_dma is 0 then 1.
4. STARVE_MAX=4, core_req held high throughout, dma_req held high -> grant order: core ×4, DMA ×1, then core ×4 again.
5. Reset asserted in the WAIT cycle of a core read -> all outputs 0 immediately; after release no core_ack appears until a new req; a fresh read completes with normal latency.
6. Core issues back-to-back reads, changing address at the ack edge (0x0 then 0x4) -> mem_en pulses are exactly 5 cycles apart (MEM_LAT=2); both acks carry the correct data.
